// File: rtl/display_page_arbiter.sv
// Fixed-priority owner of the shared time display: alert > countdown > current time,
// with a minimum hold on pop-up pages. Define DISP_ARB_BLINK_EN to blink the digit under adjustment.
module display_page_arbiter #(
    parameter int HOLD_CYCLES = 200_000_000,
    parameter int BLINK_HALF  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        adjust,
    input  logic [5:0]  blink_mask,
    output logic [31:0] time_data_out,
    output logic [2:0]  grant,
    output logic        busy
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              hold_done;
    logic [31:0]       owner0_word;
    logic [31:0]       word_next;

    assign hold_done = (hold_cnt == '0);
    assign busy      = !hold_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            time_data_out <= '0;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_next;
            time_data_out <= word_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req[2])      state_next = OWN2;
                else if (req[1]) state_next = OWN1;
            end
            OWN1: begin
                if (req[2])                     state_next = OWN2;
                else if (hold_done && !req[1])  state_next = IDLE;
            end
            OWN2: begin
                // the alert page is never preempted, only released once its hold runs out
                if (hold_done && !req[2]) state_next = req[1] ? OWN1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reload on every change of pop-up owner (including alert -> countdown), else count down to 0.
    always_comb begin
        hold_next = hold_cnt;
        if (state_next == IDLE)       hold_next = '0;
        else if (state_next != state) hold_next = HOLD_LOAD;
        else if (!hold_done)          hold_next = hold_cnt - 1'b1;
    end

    always_comb begin
        case (state)
            OWN1:    grant = 3'b010;
            OWN2:    grant = 3'b100;
            default: grant = 3'b001;
        endcase
        case (state_next)
            OWN1:    word_next = data1;
            OWN2:    word_next = data2;
            default: word_next = owner0_word;
        endcase
    end

`ifdef DISP_ARB_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    // Blink mask bit i selects nibble i + i/2 (separator nibbles 2 and 5 are skipped).
    function automatic logic [31:0] blank_nibbles(input logic [31:0] word, input logic [5:0] mask);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) w[4*(i + i/2) +: 4] = 4'b1110;
        end
        return w;
    endfunction

    // Held at zero outside adjust mode so every adjust session opens with a full on half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!adjust) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= !blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign owner0_word = (adjust && blink_off) ? blank_nibbles(data0, blink_mask) : data0;
`else
    logic unused_blink;
    assign unused_blink = ^{adjust, blink_mask};
    assign owner0_word  = data0;
`endif

endmodule
